uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer between the UART receiver and the CPU peripheral bus. Captures each completed character on the receiver's single-cycle valid strobe into a first-word-fall-through FIFO. Reports fill level, threshold and character-timeout interrupt conditions, and sticky overrun/break status flags. The bus register block reads characters through a pop strobe.

## Interface
- PAYLOAD_BITS, 8, data width per character; must match the receiver.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- RX_THRESH, 8, fill level at or above which `thresh_irq` asserts; legal range 1..2**DEPTH_LOG2.
- TIMEOUT_BITS, 40, idle bit-times with data pending before `timeout` asserts; minimum 1.
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low; clock clk.
- wr_valid  in  1  single-cycle strobe: a character has been received.
- wr_data  in  PAYLOAD_BITS  received character, valid with `wr_valid`.
- wr_break  in  1  qualifies `wr_valid`: the character is a BREAK.
- cycles_per_bit  in  32  same bit-period value fed to the receiver; the bit-time tick fires every cycles_per_bit+1 clocks.
- rd_en  in  1  pop strobe from the bus; ignored when `empty`.
- flush  in  1  discard all contents.
- clr_status  in  1  clear `overrun` and `break_det`.
- rd_data  out  PAYLOAD_BITS  head entry; defined only when !empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  number of stored entries.
- overrun  out  1  sticky: a character was dropped because the FIFO was full.
- break_det  out  1  sticky: a BREAK was received.
- timeout  out  1  character-timeout condition.
- thresh_irq  out  1  count >= RX_THRESH.
- irq  out  1  thresh_irq | timeout.

## Operation
- Storage: circular RAM, write pointer and read pointer each DEPTH_LOG2 bits, wrapping naturally at 2**DEPTH_LOG2, plus a separate count register. Full and empty are derived from count, never from pointer equality.
- Push: `wr_valid & !wr_break & (!full | pop)`. Data is written at the write pointer, and the write pointer increments.
- Pop: `rd_en & !empty`. The read pointer increments.
- Count: count + push - pop. A simultaneous push and pop leaves count unchanged, including at full and at count 1.
- BREAK (`wr_valid & wr_break`): no data is stored; sets `break_det`.
- Overrun: `wr_valid & !wr_break & full & !pop`. The character is dropped; sets `overrun`; FIFO contents are unchanged.
- Sticky flags are cleared by `clr_status`. If a set event and `clr_status` occur in the same cycle, set wins.
- Flush: pointers and count go to 0, and the timeout logic is cleared. If `wr_valid` or `rd_en` occurs in the same cycle, flush wins: the character is discarded and neither flag is set. Sticky flags are not affected by flush.
- Timeout logic: a cycle counter (32 bit) and an idle bit-time counter.
  - The cycle counter runs only while !empty. It produces a tick and wraps to 0 when it equals cycles_per_bit.
  - Each tick increments the idle counter, which saturates at TIMEOUT_BITS.
  - Any push, pop, flush, or empty state clears both counters and `timeout`.
  - `timeout` = (idle counter == TIMEOUT_BITS) & !empty.
- Reset: pointers, count, both timeout counters, `overrun` and `break_det` go to 0. Resulting outputs: empty=1, full=0, count=0, timeout=0, thresh_irq=0, irq=0. rd_data is don't-care (RAM is not reset).
- Reset mid-operation discards all contents; the first push after reset lands at address 0.

## Timing
- Push at edge N: from cycle N+1, `rd_data` shows the character if it became head, empty=0, and count is updated.
- Pop at edge N: from cycle N+1, `rd_data` shows the next entry. `rd_data` is combinational from RAM at the read pointer (first-word fall-through).
- `overrun` and `break_det` assert in the cycle after the causing `wr_valid`.
- `thresh_irq`, `full`, `empty` and `irq` are combinational from registered state, so they carry no extra latency beyond count.
- `timeout` asserts one cycle after the TIMEOUT_BITS-th tick. It deasserts in the cycle after the clearing event.
- Back-to-back `wr_valid` on consecutive cycles is supported, although the receiver never produces it.

## Test plan
- Push 0x41, 0x42, 0x43, then pop three times: rd_data sequence 0x41, 0x42, 0x43; count goes 3→0; empty=1 at end.
- Push 16 bytes 0x00..0x0F, then push 0xAA: full=1, overrun=1, count=16, and a full drain yields 0x00..0x0F. Then `clr_status`: overrun=0.
- At full, assert `wr_valid` (0x55) and `rd_en` in the same cycle: no overrun, count stays 16, and 0x55 is read last after 15 further pops. Repeat 3× to exercise pointer wrap.
- `wr_valid` with wr_break=1 and data 0x00: break_det=1, count unchanged, empty stays 1.
- cycles_per_bit=9, TIMEOUT_BITS=40, push one byte: timeout rises exactly 401 cycles after the push edge, and irq=1. A pop clears it the next cycle. Pushing 8 bytes with RX_THRESH=8 sets thresh_irq.
- Assert flush with `wr_valid` in the same cycle at count 5: count=0, empty=1, overrun=0. Assert resetn=0 mid-stream: all outputs take their reset values the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer between the UART receiver and
// the CPU bus. First-word-fall-through FIFO with fill level, threshold and
// character-timeout interrupts, plus sticky overrun/break status.
//
// Ports:
//   clk, resetn          clock; synchronous active-low reset
//   wr_valid/wr_data     single-cycle strobe + character from the receiver
//   wr_break             qualifies wr_valid: character is a BREAK (not stored)
//   cycles_per_bit       receiver bit period; bit-time tick every value+1 clocks
//   rd_en                pop strobe from the bus (ignored when empty)
//   flush                discard all contents and clear the timeout logic
//   clr_status           clear overrun / break_det (a same-cycle set wins)
//   rd_data              head entry (valid only when !empty)
//   empty/full/count     fill status
//   overrun/break_det    sticky status flags
//   timeout              character-timeout condition
//   thresh_irq, irq      count >= RX_THRESH; thresh_irq | timeout
module uart_rx_fifo #(
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned DEPTH_LOG2   = 4,
   parameter int unsigned RX_THRESH    = 8,
   parameter int unsigned TIMEOUT_BITS = 40
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    wr_valid,
   input  logic [PAYLOAD_BITS-1:0] wr_data,
   input  logic                    wr_break,
   input  logic [31:0]             cycles_per_bit,
   input  logic                    rd_en,
   input  logic                    flush,
   input  logic                    clr_status,
   output logic [PAYLOAD_BITS-1:0] rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [DEPTH_LOG2:0]     count,
   output logic                    overrun,
   output logic                    break_det,
   output logic                    timeout,
   output logic                    thresh_irq,
   output logic                    irq
);

   localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_BITS + 1);

   localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] THRESH_CNT = (DEPTH_LOG2 + 1)'(RX_THRESH);
   localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_BITS);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic [DEPTH_LOG2:0]     cnt;
   logic [31:0]             cyc_cnt;
   logic [IDLE_W-1:0]       idle_cnt;
   logic                    timeout_q;
   logic                    overrun_q;
   logic                    break_q;

   logic pop;
   logic push;
   logic drop;
   logic brk;
   logic tick;
   logic to_clear;

   always_comb begin
      empty    = (cnt == '0);
      full     = (cnt == DEPTH_CNT);
      // flush overrides every write/read event in its cycle
      pop      = rd_en & ~empty & ~flush;
      push     = wr_valid & ~wr_break & (~full | pop) & ~flush;
      drop     = wr_valid & ~wr_break & full & ~pop & ~flush;
      brk      = wr_valid & wr_break & ~flush;
      tick     = (cyc_cnt == cycles_per_bit);
      to_clear = push | pop | flush | empty;
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (resetn && push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

   // Sticky flags: a set event in the same cycle as clr_status wins
   always_ff @(posedge clk) begin
      if (!resetn) begin
         overrun_q <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         if (drop)
            overrun_q <= 1'b1;
         else if (clr_status)
            overrun_q <= 1'b0;
         if (brk)
            break_q <= 1'b1;
         else if (clr_status)
            break_q <= 1'b0;
      end
   end

   // Character timeout: bit-time ticks counted while data sits unread.
   // timeout is registered from the saturated idle count, so it rises one
   // cycle after the final tick.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cyc_cnt   <= '0;
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (to_clear) begin
         cyc_cnt   <= '0;
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= (idle_cnt == IDLE_MAX);
         if (tick) begin
            cyc_cnt <= '0;
            if (idle_cnt != IDLE_MAX)
               idle_cnt <= idle_cnt + 1'b1;
         end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
         end
      end
   end

   always_comb begin
      rd_data    = mem[rd_ptr];
      count      = cnt;
      overrun    = overrun_q;
      break_det  = break_q;
      timeout    = timeout_q & ~empty;
      thresh_irq = (cnt >= THRESH_CNT);
      irq        = thresh_irq | timeout;
   end

endmodule
